// File: rtl/hyperbus_axi_cmd_arb.sv
// hyperbus_axi_cmd_arb: AXI AW/AR command arbiter issuing one HyperBus transfer at a time.
// Define HYPERBUS_ARB_WRITE_PRIO_EN for strict write priority instead of round-robin.
module hyperbus_axi_cmd_arb #(
  parameter int IdWidth   = 10,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic [7:0]           aw_len_i,
  input  logic [2:0]           aw_size_i,
  input  logic [1:0]           aw_burst_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic [2:0]           ar_size_i,
  input  logic [1:0]           ar_burst_i,
  output logic                 trans_valid_o,
  input  logic                 trans_ready_i,
  output logic                 trans_write_o,
  output logic [AddrWidth-1:0] trans_addr_o,
  output logic [8:0]           trans_words_o,
  output logic                 trans_wrap_o,
  output logic [IdWidth-1:0]   trans_id_o,
  input  logic                 trans_done_i,
  output logic                 err_valid_o,
  input  logic                 err_ready_i,
  output logic                 err_write_o,
  output logic [IdWidth-1:0]   err_id_o,
  output logic [7:0]           err_len_o,
  output logic                 busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ERR} state_e;
  state_e               state_q;
  logic                 grant_w, grant_r, hs, illegal_d;
  logic [IdWidth-1:0]   id_d, id_q;
  logic [AddrWidth-1:0] addr_d, addr_q;
  logic [7:0]           len_d, len_q;
  logic [2:0]           size_d;
  logic [1:0]           burst_d;
  logic                 write_q, wrap_q;
`ifdef HYPERBUS_ARB_WRITE_PRIO_EN
  assign grant_w = aw_valid_i;
`else
  logic last_w_q;
  always_ff @(posedge clk_sys_i or negedge rst_ni)
    if (!rst_ni) last_w_q <= 1'b1;
    else if (hs) last_w_q <= aw_ready_o;
  assign grant_w = aw_valid_i & (~ar_valid_i | ~last_w_q);
`endif
  assign grant_r = ar_valid_i & ~grant_w;
  // Readys are gated by reset so every output is low while rst_ni is asserted.
  assign aw_ready_o = rst_ni & (state_q == IDLE) & grant_w;
  assign ar_ready_o = rst_ni & (state_q == IDLE) & grant_r;
  assign hs = aw_ready_o | ar_ready_o;
  always_comb begin
    id_d      = grant_w ? aw_id_i    : ar_id_i;
    addr_d    = grant_w ? aw_addr_i  : ar_addr_i;
    len_d     = grant_w ? aw_len_i   : ar_len_i;
    size_d    = grant_w ? aw_size_i  : ar_size_i;
    burst_d   = grant_w ? aw_burst_i : ar_burst_i;
    illegal_d = (burst_d == 2'b00) | (burst_d == 2'b11) | (size_d > 3'd1) |
                ((burst_d == 2'b10) & ~((len_d == 8'd1) | (len_d == 8'd3) | (len_d == 8'd7) | (len_d == 8'd15)));
  end
  always_ff @(posedge clk_sys_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (hs) begin
          write_q <= grant_w;
          id_q    <= id_d;
          addr_q  <= addr_d & ~AddrWidth'(1);
          len_q   <= len_d;
          wrap_q  <= burst_d == 2'b10;
          state_q <= illegal_d ? ERR : ISSUE;
        end
        ISSUE:     if (trans_ready_i) state_q <= WAIT_DONE;
        WAIT_DONE: if (trans_done_i) state_q <= IDLE;
        default:   if (err_ready_i) state_q <= IDLE;
      endcase
    end
  assign trans_valid_o = state_q == ISSUE;
  assign err_valid_o   = state_q == ERR;
  assign busy_o        = state_q != IDLE;
  assign trans_write_o = write_q;
  assign trans_addr_o  = addr_q;
  assign trans_words_o = {1'b0, len_q} + 9'd1;
  assign trans_wrap_o  = wrap_q;
  assign trans_id_o    = id_q;
  assign err_write_o   = write_q;
  assign err_id_o      = id_q;
  assign err_len_o     = len_q;
endmodule

// File: tb/tb_hyperbus_axi_cmd_arb.sv
// tb_hyperbus_axi_cmd_arb: directed and randomized checks of the command arbiter against a behavioural model.
module tb_hyperbus_axi_cmd_arb;
  localparam int IW = 10, AW = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic aw_valid = 0, ar_valid = 0, trans_ready = 0, trans_done = 0, err_ready = 0;
  logic [IW-1:0] aw_id = '0, ar_id = '0;
  logic [AW-1:0] aw_addr = '0, ar_addr = '0;
  logic [7:0] aw_len = '0, ar_len = '0;
  logic [2:0] aw_size = '0, ar_size = '0;
  logic [1:0] aw_burst = '0, ar_burst = '0;
  logic aw_ready, ar_ready, trans_valid, trans_write, trans_wrap, err_valid, err_write, busy;
  logic [AW-1:0] trans_addr;
  logic [8:0] trans_words;
  logic [IW-1:0] trans_id, err_id;
  logic [7:0] err_len;
  int vec = 0, bad = 0;
  bit exp_last_w = 1'b1;

  hyperbus_axi_cmd_arb #(.IdWidth(IW), .AddrWidth(AW)) dut (
    .clk_sys_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
    .aw_len_i(aw_len), .aw_size_i(aw_size), .aw_burst_i(aw_burst),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
    .trans_valid_o(trans_valid), .trans_ready_i(trans_ready), .trans_write_o(trans_write),
    .trans_addr_o(trans_addr), .trans_words_o(trans_words), .trans_wrap_o(trans_wrap),
    .trans_id_o(trans_id), .trans_done_i(trans_done),
    .err_valid_o(err_valid), .err_ready_i(err_ready), .err_write_o(err_write),
    .err_id_o(err_id), .err_len_o(err_len), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // A burst is acceptable only as INCR, or as WRAP of 2/4/8/16 beats, with at most 2-byte beats.
  function automatic bit legal(input logic [1:0] b, input logic [2:0] s, input logic [7:0] l);
    int beats = int'(l) + 1;
    if (s > 3'd1) return 1'b0;
    if (b == 2'd1) return 1'b1;
    if (b == 2'd2) return beats == 2 || beats == 4 || beats == 8 || beats == 16;
    return 1'b0;
  endfunction

  function automatic bit pick_w(input bit aw, input bit ar);
    if (!ar) return 1'b1;
    if (!aw) return 1'b0;
`ifdef HYPERBUS_ARB_WRITE_PRIO_EN
    return 1'b1;
`else
    return !exp_last_w;
`endif
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    aw_id = id; aw_addr = a; aw_len = l; aw_size = s; aw_burst = b; aw_valid = 1'b1;
  endtask

  task automatic drive_ar(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    ar_id = id; ar_addr = a; ar_len = l; ar_size = s; ar_burst = b; ar_valid = 1'b1;
  endtask

  task automatic accept(output bit w);
    int ch = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (aw_valid && aw_ready) ch = 1;
      else if (ar_valid && ar_ready) ch = 0;
      if (ch >= 0) break;
    end
    if (ch < 0) begin
      vec++; bad++;
      $display("FAIL accept_timeout got no handshake want one within 20 cycles");
    end
    w = ch == 1;
    @(posedge clk); #1;
    aw_valid = 1'b0; ar_valid = 1'b0;
  endtask

  task automatic take_cmd(input int d);
    repeat (d) tick;
    trans_ready = 1'b1; tick; trans_ready = 1'b0;
  endtask

  task automatic finish(input int d);
    repeat (d) tick;
    trans_done = 1'b1; tick; trans_done = 1'b0;
  endtask

  task automatic take_err(input int d);
    repeat (d) tick;
    err_ready = 1'b1; tick; err_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    vec++; if ({trans_valid, err_valid, busy, aw_ready, ar_ready} !== 5'b0) begin bad++;
      $display("FAIL reset_outs got %b want 00000", {trans_valid, err_valid, busy, aw_ready, ar_ready}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec++; if ({trans_valid, err_valid, busy, aw_ready, ar_ready} !== 5'b0) begin bad++;
      $display("FAIL idle_outs got %b want 00000", {trans_valid, err_valid, busy, aw_ready, ar_ready}); end
    vec++; if ({trans_addr, trans_id, err_len} !== '0) begin bad++;
      $display("FAIL reset_fields got %h/%h/%h want 0", trans_addr, trans_id, err_len); end
    tick;
  endtask

  task automatic test_round_robin;
    bit w, ew;
    logic [IW-1:0] wid, rid;
    for (int k = 0; k < 4; k++) begin
      wid = IW'($urandom); rid = IW'($urandom);
      drive_aw(wid, $urandom, 8'($urandom_range(0, 255)), 3'd1, 2'd1);
      drive_ar(rid, $urandom, 8'($urandom_range(0, 255)), 3'd1, 2'd1);
      ew = pick_w(1'b1, 1'b1);
      accept(w);
      exp_last_w = ew;
      vec++; if (w !== ew) begin bad++; $display("FAIL rr_grant%0d got w=%0b want w=%0b", k, w, ew); end
      vec++; if ({trans_valid, trans_write, trans_id} !== {1'b1, ew, ew ? wid : rid}) begin bad++;
        $display("FAIL rr_cmd%0d got %b/%b/%h want 1/%b/%h", k, trans_valid, trans_write, trans_id, ew, ew ? wid : rid); end
      take_cmd(0);
      finish(2);
    end
  endtask

  task automatic test_single_read;
    bit w;
    logic [IW-1:0] id = IW'($urandom);
    drive_ar(id, 32'h1003, 8'd7, 3'd1, 2'd1);
    vec++; if (trans_valid !== 1'b0) begin bad++; $display("FAIL rd_pre_valid got %b want 0", trans_valid); end
    accept(w);
    exp_last_w = 1'b0;
    vec++; if (w !== 1'b0) begin bad++; $display("FAIL rd_grant got w=%b want w=0", w); end
    vec++; if ({trans_valid, trans_write, trans_addr, trans_words, trans_wrap, trans_id} !== {1'b1, 1'b0, 32'h1002, 9'd8, 1'b0, id}) begin bad++;
      $display("FAIL rd_cmd got %b %b %h %0d %b %h want 1 0 00001002 8 0 %h", trans_valid, trans_write, trans_addr, trans_words, trans_wrap, trans_id, id); end
    take_cmd(0);
    vec++; if ({busy, trans_valid} !== 2'b10) begin bad++; $display("FAIL rd_wait got busy/valid %b want 10", {busy, trans_valid}); end
    trans_done = 1'b1; tick; trans_done = 1'b0;
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_drop got %b want 0", busy); end
  endtask

  task automatic test_illegal;
    bit w;
    logic [IW-1:0] id;
    logic [7:0] l;
    for (int i = 0; i < 3; i++) begin
      id = IW'($urandom);
      l = i == 2 ? 8'd5 : 8'($urandom);
      if (i == 0) drive_aw(id, $urandom, l, 3'd1, 2'd0);
      else if (i == 1) drive_ar(id, $urandom, l, 3'd2, 2'd1);
      else drive_aw(id, $urandom, l, 3'd1, 2'd2);
      accept(w);
      exp_last_w = i != 1;
      vec++; if ({err_valid, trans_valid} !== 2'b10) begin bad++;
        $display("FAIL ill%0d_valids got err/trans %b want 10", i, {err_valid, trans_valid}); end
      vec++; if ({err_write, err_id, err_len} !== {i != 1, id, l}) begin bad++;
        $display("FAIL ill%0d_fields got %b/%h/%0d want %b/%h/%0d", i, err_write, err_id, err_len, i != 1, id, l); end
      take_err(int'($urandom_range(0, 2)));
      vec++; if ({busy, trans_valid} !== 2'b00) begin bad++; $display("FAIL ill%0d_after got %b want 00", i, {busy, trans_valid}); end
    end
  endtask

  task automatic test_wrap15;
    bit w;
    drive_ar(IW'($urandom), 32'h40, 8'd15, 3'd1, 2'd2);
    accept(w);
    exp_last_w = 1'b0;
    vec++; if ({trans_valid, trans_wrap, trans_words} !== {1'b1, 1'b1, 9'd16}) begin bad++;
      $display("FAIL wrap15 got valid/wrap/words %b/%b/%0d want 1/1/16", trans_valid, trans_wrap, trans_words); end
    take_cmd(1);
    finish(1);
  endtask

  task automatic test_backpressure;
    bit w;
    logic [IW-1:0] id = IW'($urandom);
    logic [AW-1:0] a = $urandom;
    logic [7:0] l = 8'($urandom);
    drive_aw(id, a, l, 3'd0, 2'd1);
    accept(w);
    exp_last_w = 1'b1;
    aw_valid = 1'b1; ar_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vec++; if ({trans_valid, aw_ready, ar_ready, trans_write, trans_addr, trans_words, trans_id} !==
                 {3'b100, 1'b1, a & ~32'h1, 9'(l) + 9'd1, id}) begin bad++;
        $display("FAIL bp_hold%0d got %b%b%b %b %h %0d %h", i, trans_valid, aw_ready, ar_ready, trans_write, trans_addr, trans_words, trans_id); end
      trans_done = i == 3;
      tick;
    end
    trans_done = 1'b0; aw_valid = 1'b0; ar_valid = 1'b0;
    take_cmd(0);
    vec++; if ({busy, trans_valid} !== 2'b10) begin bad++; $display("FAIL bp_wait got %b want 10", {busy, trans_valid}); end
    finish(0);
  endtask

  task automatic test_reset_mid;
    bit w;
    drive_aw(IW'($urandom), $urandom, 8'd3, 3'd1, 2'd1);
    accept(w);
    take_cmd(0);
    drive_ar(IW'($urandom), 32'h2000, 8'd1, 3'd1, 2'd1);
    @(negedge clk); rst_n = 1'b0; #1;
    exp_last_w = 1'b1;
    vec++; if ({trans_valid, err_valid, busy, aw_ready, ar_ready, trans_id, err_len} !== '0) begin bad++;
      $display("FAIL rst_mid got %b %h %h want all 0", {trans_valid, err_valid, busy, aw_ready, ar_ready}, trans_id, err_len); end
    @(negedge clk); rst_n = 1'b1; #1;
    vec++; if (ar_ready !== 1'b1) begin bad++; $display("FAIL rst_first_accept got ar_ready %b want 1", ar_ready); end
    @(posedge clk); #1;
    ar_valid = 1'b0;
    exp_last_w = 1'b0;
    vec++; if ({trans_valid, trans_write, trans_addr} !== {2'b10, 32'h2000}) begin bad++;
      $display("FAIL rst_cmd got %b/%b/%h want 1/0/00002000", trans_valid, trans_write, trans_addr); end
    take_cmd(0);
    finish(0);
  endtask

  task automatic test_random;
    bit w, ew, aw_on, ar_on;
    logic [IW-1:0] id[2];
    logic [AW-1:0] a[2];
    logic [7:0] l[2];
    logic [2:0] s[2];
    logic [1:0] b[2];
    logic [7:0] lens[6] = '{8'd0, 8'd1, 8'd3, 8'd5, 8'd7, 8'd15};
    int c;
    for (int n = 0; n < 40; n++) begin
      c = int'($urandom_range(1, 3));
      aw_on = c[0]; ar_on = c[1];
      for (int j = 0; j < 2; j++) begin
        id[j] = IW'($urandom); a[j] = $urandom;
        l[j] = ($urandom % 2) ? lens[$urandom % 6] : 8'($urandom);
        s[j] = 3'($urandom_range(0, 2)); b[j] = 2'($urandom);
      end
      if (aw_on) drive_aw(id[1], a[1], l[1], s[1], b[1]);
      if (ar_on) drive_ar(id[0], a[0], l[0], s[0], b[0]);
      ew = pick_w(aw_on, ar_on);
      accept(w);
      exp_last_w = ew;
      c = ew ? 1 : 0;
      vec++; if (w !== ew) begin bad++; $display("FAIL rnd%0d_grant got w=%b want w=%b", n, w, ew); end
      if (legal(b[c], s[c], l[c])) begin
        vec++; if ({trans_valid, err_valid, trans_write, trans_addr, trans_words, trans_wrap, trans_id} !==
                   {2'b10, ew, a[c] & ~32'h1, 9'(l[c]) + 9'd1, b[c] == 2'd2, id[c]}) begin bad++;
          $display("FAIL rnd%0d_cmd got %b%b %b %h %0d %b %h want 10 %b %h %0d %b %h", n, trans_valid, err_valid, trans_write,
                   trans_addr, trans_words, trans_wrap, trans_id, ew, a[c] & ~32'h1, 9'(l[c]) + 9'd1, b[c] == 2'd2, id[c]); end
        take_cmd(int'($urandom_range(0, 3)));
        finish(int'($urandom_range(0, 3)));
      end else begin
        vec++; if ({err_valid, trans_valid, err_write, err_id, err_len} !== {2'b10, ew, id[c], l[c]}) begin bad++;
          $display("FAIL rnd%0d_err got %b%b %b %h %0d want 10 %b %h %0d", n, err_valid, trans_valid, err_write, err_id, err_len, ew, id[c], l[c]); end
        take_err(int'($urandom_range(0, 3)));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_round_robin;
    test_single_read;
    test_illegal;
    test_wrap15;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
